// File: rtl/act_result_collector_if.sv
// Bus between the activation-result collector and its producer/consumer.
// oMin/oMax exist only when ACT_COLLECT_MINMAX_EN is defined.
interface act_result_collector_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
);
   localparam int ADDR_W = $clog2(DEPTH);

   // Capture side: rdy strobes data in when enable is high; there is no back-pressure.
   // Drain side: a word transfers on every cycle where oValid and iReady are both high;
   // oData/oValid hold steady while oValid & !iReady; iReady is ignored while oValid is low.
   logic                    enable;
   logic                    rdy;
   logic signed [WIDTH-1:0] data;
   logic signed [WIDTH-1:0] oData;
   logic                    oValid;
   logic                    iReady;
   logic [ADDR_W:0]         oCount;
   logic                    oFull;
   logic                    oEmpty;
   logic                    oOverflow;
   logic [CNT_W-1:0]        oSampleCnt;
`ifdef ACT_COLLECT_MINMAX_EN
   logic signed [WIDTH-1:0] oMin;
   logic signed [WIDTH-1:0] oMax;
`endif

   modport master (
      input  enable, rdy, data, iReady,
      output oData, oValid, oCount, oFull, oEmpty, oOverflow, oSampleCnt
`ifdef ACT_COLLECT_MINMAX_EN
      , output oMin, oMax
`endif
   );

   modport slave (
      output enable, rdy, data, iReady,
      input  oData, oValid, oCount, oFull, oEmpty, oOverflow, oSampleCnt
`ifdef ACT_COLLECT_MINMAX_EN
      , input oMin, oMax
`endif
   );
endinterface

// File: rtl/act_result_collector.sv
// Collects activation-unit samples into a first-word-fall-through FIFO and drains them downstream.
// Optional running min/max tracking is enabled by defining ACT_COLLECT_MINMAX_EN.
module act_result_collector #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iFlush,
   act_result_collector_if.master bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic signed [WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]       wr_ptr;
   logic [ADDR_W-1:0]       rd_ptr;
   logic [ADDR_W:0]         count_q;
   logic [ADDR_W:0]         count_nxt;
   logic                    full_q;
   logic                    empty_q;
   logic                    overflow_q;
   logic [CNT_W-1:0]        sample_cnt_q;
   logic                    clear;
   logic                    push_req;
   logic                    pop;
   logic                    push_ok;
   logic                    push_drop;

   assign clear     = iRst | iFlush;
   assign push_req  = bus.enable & bus.rdy;
   assign pop       = ~empty_q & bus.iReady;
   // A full FIFO still takes a sample when the head leaves in the same cycle.
   assign push_ok   = push_req & (~full_q | pop);
   assign push_drop = push_req & full_q & ~pop;

   always_comb begin
      count_nxt = count_q;
      if (push_ok && !pop)
         count_nxt = count_q + 1'b1;
      else if (!push_ok && pop)
         count_nxt = count_q - 1'b1;
   end

   always_ff @(posedge iClk) begin
      if (clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         overflow_q   <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (sample_cnt_q != '1)
               sample_cnt_q <= sample_cnt_q + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_drop)
            overflow_q <= 1'b1;
         count_q <= count_nxt;
         full_q  <= (count_nxt == FULL_CNT);
         empty_q <= (count_nxt == '0);
      end
   end

   // Storage is not reset; the empty flag masks stale contents on oData.
   always_ff @(posedge iClk) begin
      if (push_ok && !clear)
         mem[wr_ptr] <= bus.data;
   end

   assign bus.oData      = empty_q ? '0 : mem[rd_ptr];
   assign bus.oValid     = ~empty_q;
   assign bus.oCount     = count_q;
   assign bus.oFull      = full_q;
   assign bus.oEmpty     = empty_q;
   assign bus.oOverflow  = overflow_q;
   assign bus.oSampleCnt = sample_cnt_q;

`ifdef ACT_COLLECT_MINMAX_EN
   localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH-1:0] min_q;
   logic signed [WIDTH-1:0] max_q;

   always_ff @(posedge iClk) begin
      if (clear) begin
         min_q <= POS_MAX;
         max_q <= NEG_MAX;
      end else if (push_ok) begin
         if (bus.data < min_q)
            min_q <= bus.data;
         if (bus.data > max_q)
            max_q <= bus.data;
      end
   end

   assign bus.oMin = min_q;
   assign bus.oMax = max_q;
`endif
endmodule
